// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return stack slice.
// Holds the default geometry and the command priority encoder.
package pc_pkg;

  localparam int PC_AW        = 8;
  localparam int PC_DEPTH     = 4;
  localparam int PC_RESET_VEC = 0;
  localparam int SP_W         = $clog2(PC_DEPTH) + 1;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_BRANCH,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } cmd_e;

  // Only the highest-priority request acts: ret > call > load > branch > inc.
  function automatic cmd_e sel_cmd(input logic inc, input logic load, input logic branch,
                                   input logic call, input logic ret);
    if (ret)         return CMD_RET;
    else if (call)   return CMD_CALL;
    else if (load)   return CMD_LOAD;
    else if (branch) return CMD_BRANCH;
    else if (inc)    return CMD_INC;
    else             return CMD_HOLD;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Push/pop are ignored when full/empty; error policy
// lives in the caller.
module pc_ret_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          push_data,
  output logic [AW-1:0]          top_data,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   full,
  output logic                   empty
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;

  logic [AW-1:0] mem [DEPTH];

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);

  always_ff @(posedge clock) begin
    if (reset)
      sp <= '0;
    else if (push && !full)
      sp <= sp + SPW'(1);
    else if (pop && !empty)
      sp <= sp - SPW'(1);
  end

  // Contents are deliberately not reset; sp alone defines validity.
  always_ff @(posedge clock) begin
    if (push && !full)
      mem[sp[IW-1:0]] <= push_data;
  end

  assign top_data = mem[sp[IW-1:0] - IW'(1)];

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with hardware call/return stack and sticky
// overflow/underflow flags.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int AW        = PC_AW,
  parameter int DEPTH     = PC_DEPTH,
  parameter int RESET_VEC = PC_RESET_VEC
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   inc,
  input  logic                   load,
  input  logic                   branch,
  input  logic                   call,
  input  logic                   ret,
  input  logic [AW-1:0]          target_in,
  input  logic [AW-1:0]          offset_in,
  output logic [AW-1:0]          pc_out,
  output logic [$clog2(DEPTH):0] sp_out,
  output logic                   stk_full,
  output logic                   stk_empty,
  output logic                   ovf_err,
  output logic                   unf_err
);

  cmd_e          cmd;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] ret_addr;
  logic          push;
  logic          pop;

  assign cmd = stall ? CMD_HOLD : sel_cmd(inc, load, branch, call, ret);

  pc_ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_out + AW'(1)),
    .top_data  (ret_addr),
    .sp        (sp_out),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Same-width addition wraps modulo 2^AW, which also gives signed branch offsets.
  always_comb begin
    pc_next = pc_out;
    push    = 1'b0;
    pop     = 1'b0;
    case (cmd)
      CMD_INC:    pc_next = pc_out + AW'(1);
      CMD_BRANCH: pc_next = pc_out + offset_in;
      CMD_LOAD:   pc_next = target_in;
      CMD_CALL: begin
        if (!stk_full) begin
          push    = 1'b1;
          pc_next = target_in;
        end
      end
      CMD_RET: begin
        if (!stk_empty) begin
          pop     = 1'b1;
          pc_next = ret_addr;
        end
      end
      default: pc_next = pc_out;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_out  <= AW'(RESET_VEC);
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      pc_out <= pc_next;
      if (cmd == CMD_CALL && stk_full)
        ovf_err <= 1'b1;
      if (cmd == CMD_RET && stk_empty)
        unf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_pc_call_stack;
  import pc_pkg::*;

  logic            clock;
  logic            reset;
  logic            stall, inc, load, branch, call, ret;
  logic [7:0]      target_in, offset_in;
  logic [7:0]      pc_out;
  logic [SP_W-1:0] sp_out;
  logic            stk_full, stk_empty, ovf_err, unf_err;

  int n_tests = 0;
  int n_fail  = 0;

  pc_call_stack #(.AW(8), .DEPTH(4), .RESET_VEC(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .inc       (inc),
    .load      (load),
    .branch    (branch),
    .call      (call),
    .ret       (ret),
    .target_in (target_in),
    .offset_in (offset_in),
    .pc_out    (pc_out),
    .sp_out    (sp_out),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: return stack as a queue, priority as an if/else chain.
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_ovf, m_unf, m_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_valid = 1'b1;
    end else if (stall) begin
    end else if (ret) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (call) begin
      if (m_stk.size() == 4) m_ovf = 1'b1;
      else begin
        m_stk.push_back(8'((int'(m_pc) + 1) % 256));
        m_pc = target_in;
      end
    end else if (load) begin
      m_pc = target_in;
    end else if (branch) begin
      m_pc = 8'((int'(m_pc) + int'($signed(offset_in)) + 256) % 256);
    end else if (inc) begin
      m_pc = 8'((int'(m_pc) + 1) % 256);
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_pc",    32'(pc_out),    32'(m_pc));
      check("model_sp",    32'(sp_out),    32'(m_stk.size()));
      check("model_full",  32'(stk_full),  32'(m_stk.size() == 4));
      check("model_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
      check("model_ovf",   32'(ovf_err),   32'(m_ovf));
      check("model_unf",   32'(unf_err),   32'(m_unf));
    end
  end

  // One clock of stimulus; returns just after the active edge.
  task automatic cyc(input logic rs, input logic st, input logic i, input logic l,
                     input logic b, input logic c, input logic r,
                     input logic [7:0] tgt, input logic [7:0] off);
    @(negedge clock);
    reset = rs; stall = st; inc = i; load = l; branch = b; call = c; ret = r;
    target_in = tgt; offset_in = off;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();            cyc(0,0,0,0,0,0,0, 8'h00, 8'h00); endtask
  task automatic do_inc();          cyc(0,0,1,0,0,0,0, 8'h00, 8'h00); endtask
  task automatic do_load(input logic [7:0] t);   cyc(0,0,0,1,0,0,0, t, 8'h00); endtask
  task automatic do_branch(input logic [7:0] o); cyc(0,0,0,0,1,0,0, 8'h00, o); endtask
  task automatic do_call(input logic [7:0] t);   cyc(0,0,0,0,0,1,0, t, 8'h00); endtask
  task automatic do_ret();          cyc(0,0,0,0,0,0,1, 8'h00, 8'h00); endtask

  initial begin
    reset = 1'b1; stall = 0; inc = 0; load = 0; branch = 0; call = 0; ret = 0;
    target_in = 8'h00; offset_in = 8'h00;

    // 1: reset state, increments, hold
    cyc(1,0,0,0,0,0,0, 8'h00, 8'h00);
    check("rst_pc", 32'(pc_out), 32'h00);
    check("rst_sp", 32'(sp_out), 32'd0);
    check("rst_empty", 32'(stk_empty), 32'd1);
    check("rst_full", 32'(stk_full), 32'd0);
    check("rst_flags", 32'({ovf_err, unf_err}), 32'd0);
    do_inc(); check("inc1", 32'(pc_out), 32'h01);
    do_inc(); check("inc2", 32'(pc_out), 32'h02);
    do_inc(); check("inc3", 32'(pc_out), 32'h03);
    idle();   check("hold", 32'(pc_out), 32'h03);

    // 2: wraparound and signed branches
    do_load(8'hFF); do_inc(); check("inc_wrap", 32'(pc_out), 32'h00);
    do_load(8'h10); do_branch(8'hF0); check("br_neg", 32'(pc_out), 32'h00);
    do_load(8'h10); do_branch(8'h05); check("br_pos", 32'(pc_out), 32'h15);
    do_load(8'h02); do_branch(8'hFE); check("br_m2", 32'(pc_out), 32'h00);
    do_load(8'hFF); do_branch(8'h01); check("br_wrap", 32'(pc_out), 32'h00);

    // 3: nested call / return
    do_load(8'h10);
    do_call(8'h40); check("call1_pc", 32'(pc_out), 32'h40); check("call1_sp", 32'(sp_out), 32'd1);
    do_call(8'h80); check("call2_pc", 32'(pc_out), 32'h80); check("call2_sp", 32'(sp_out), 32'd2);
    do_ret();       check("ret1_pc", 32'(pc_out), 32'h41);  check("ret1_sp", 32'(sp_out), 32'd1);
    do_ret();       check("ret2_pc", 32'(pc_out), 32'h11);  check("ret2_sp", 32'(sp_out), 32'd0);
    check("ret2_empty", 32'(stk_empty), 32'd1);

    // 4: fill, overflow, unwind
    do_call(8'h20); do_call(8'h30); do_call(8'h40); do_call(8'h50);
    check("fill_full", 32'(stk_full), 32'd1);
    check("fill_pc", 32'(pc_out), 32'h50);
    do_call(8'hC0);
    check("ovf_pc", 32'(pc_out), 32'h50);
    check("ovf_flag", 32'(ovf_err), 32'd1);
    check("ovf_sp", 32'(sp_out), 32'd4);
    do_ret(); check("unw1", 32'(pc_out), 32'h41);
    do_ret(); check("unw2", 32'(pc_out), 32'h31);
    do_ret(); check("unw3", 32'(pc_out), 32'h21);
    do_ret(); check("unw4", 32'(pc_out), 32'h12);
    check("unw_sp", 32'(sp_out), 32'd0);
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // 5: underflow, then normal operation continues
    do_ret();
    check("unf_pc", 32'(pc_out), 32'h12);
    check("unf_flag", 32'(unf_err), 32'd1);
    do_inc(); check("unf_inc", 32'(pc_out), 32'h13);

    // 6: priority, stall, reset
    cyc(0,0,1,1,1,0,0, 8'h30, 8'h05); check("pri_load", 32'(pc_out), 32'h30);
    do_call(8'h60);
    cyc(0,0,0,0,0,1,1, 8'h90, 8'h00);
    check("pri_ret_pc", 32'(pc_out), 32'h31);
    check("pri_ret_sp", 32'(sp_out), 32'd0);
    cyc(0,1,0,0,0,1,0, 8'h77, 8'h00);
    check("stall_pc", 32'(pc_out), 32'h31);
    check("stall_sp", 32'(sp_out), 32'd0);
    cyc(1,0,0,0,0,1,0, 8'h55, 8'h00);
    check("rstcall_pc", 32'(pc_out), 32'h00);
    check("rstcall_sp", 32'(sp_out), 32'd0);
    check("rstcall_flags", 32'({ovf_err, unf_err}), 32'd0);
    cyc(0,1,0,0,0,0,1, 8'h00, 8'h00);
    check("stall_noflag", 32'(unf_err), 32'd0);
    do_call(8'hA0); do_call(8'hB0); do_call(8'hC0); do_call(8'hD0);
    cyc(0,1,0,0,0,1,0, 8'hE0, 8'h00);
    check("stall_noovf", 32'(ovf_err), 32'd0);
    check("stall_full_pc", 32'(pc_out), 32'hD0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
